// File: rtl/icache_refill_pkg.sv
// rtl/icache_refill_pkg.sv - shared state encodings and RVC helpers for the icache refill engine
//
// Contents:
//   icr_state_t  refill FSM states (ICR_IDLE, ICR_REQ, ICR_READ, ICR_WRITE)
//   RVC_MASK     opcode bits that are 2'b11 for a full 32-bit instruction
//   IC_WIDTH     cache line width, kept with the other cache-wide constants
//   is_rvc()     true when byte 0 marks a compressed instruction
package icache_refill_pkg;

  typedef enum logic [1:0] {
    ICR_IDLE  = 2'd0,
    ICR_REQ   = 2'd1,
    ICR_READ  = 2'd2,
    ICR_WRITE = 2'd3
  } icr_state_t;

  localparam logic [1:0] RVC_MASK = 2'b11;
  localparam int         IC_WIDTH = 32;

  function automatic logic is_rvc(input logic [7:0] byte0);
    return byte0[1:0] != RVC_MASK;
  endfunction

endpackage

// File: rtl/icr_byte_sampler.sv
// rtl/icr_byte_sampler.sv - read-latency tag pipe that steers memory bytes into the refill buffer
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   en         global enable; all state holds when low
//   clr        flush; drops in-flight tags and the byte buffer (acts only when en)
//   push_valid a byte address is presented on the bus this cycle
//   push_idx   byte index (0..3) of that address
//   din        memory read data
//   mat_valid  the tag matures this cycle, din holds byte mat_idx
//   mat_idx    byte index of the maturing tag
//   bytes      captured bytes 0..2; byte 3 is consumed straight from din
module icr_byte_sampler #(
  parameter int RD_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic            push_valid,
  input  logic [1:0]      push_idx,
  input  logic [7:0]      din,
  output logic            mat_valid,
  output logic [1:0]      mat_idx,
  output logic [2:0][7:0] bytes
);

  logic [RD_LATENCY-1:0]      tag_v;
  logic [RD_LATENCY-1:0][1:0] tag_i;

  // Bit 0 of the widened vectors is the tag entering this cycle, so a single
  // slice works as the shift for any depth including 1.
  logic [RD_LATENCY:0]        tag_v_all;
  logic [RD_LATENCY:0][1:0]   tag_i_all;

  assign tag_v_all = {tag_v, push_valid};
  assign tag_i_all = {tag_i, push_idx};

  assign mat_valid = tag_v[RD_LATENCY-1];
  assign mat_idx   = tag_i[RD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst || (en && clr)) begin
      tag_v <= '0;
      tag_i <= '0;
      bytes <= '0;
    end else if (en) begin
      tag_v <= tag_v_all[RD_LATENCY-1:0];
      tag_i <= tag_i_all[RD_LATENCY-1:0];
      if (mat_valid) begin
        case (mat_idx)
          2'd0:    bytes[0] <= din;
          2'd1:    bytes[1] <= din;
          2'd2:    bytes[2] <= din;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - instruction cache miss-refill engine over a byte-wide memory bus
//
// Optional feature macro: ICR_PERF_EN (adds perf_refills, perf_compressed, perf_flushed)
//
// Ports:
//   clk_in                  clock
//   rst_in                  synchronous active-high reset
//   rdy_in                  global enable; all state holds when low
//   flush_in                abort the current refill
//   miss_valid, miss_addr   refill request, halfword address [31:1]
//   busy                    high whenever not idle
//   mem_req, mem_gnt        bus request / arbiter grant
//   mem_a, mem_din          byte address out, read data in (RD_LATENCY cycles later)
//   write_ic_rdy            one-cycle cache write strobe
//   write_ic_addr           halfword address of the filled entry
//   write_ic_data           instruction, upper half zero when compressed
//   write_ic_is_compressed  byte0[1:0] != 2'b11
//   perf_*                  wrapping event counters (ICR_PERF_EN only)
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        miss_valid,
  input  logic [30:0] miss_addr,
  output logic        busy,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_a,
  input  logic [7:0]  mem_din,
  output logic        write_ic_rdy,
  output logic [30:0] write_ic_addr,
  output logic [31:0] write_ic_data,
  output logic        write_ic_is_compressed
`ifdef ICR_PERF_EN
  ,
  output logic [31:0] perf_refills,
  output logic [31:0] perf_compressed,
  output logic [31:0] perf_flushed
`endif
);

  icr_state_t     state;
  logic [30:0]    base;
  logic           issue;      // mem_a currently presents a byte that must be tagged
  logic [1:0]     issue_idx;

  logic           push_valid;
  logic [1:0]     push_idx;
  logic           mat_valid;
  logic [1:0]     mat_idx;
  logic [2:0][7:0] bytes;

  logic           full_go;
  logic           last_byte;
  logic           comp_now;

  // Byte 0 goes out in the grant cycle itself; later bytes follow the issue register.
  always_comb begin
    push_valid = 1'b0;
    push_idx   = issue_idx;
    if (state == ICR_REQ && mem_req && mem_gnt) begin
      push_valid = 1'b1;
      push_idx   = 2'd0;
    end else if (state == ICR_READ && issue) begin
      push_valid = 1'b1;
    end
  end

  icr_byte_sampler #(
    .RD_LATENCY (RD_LATENCY)
  ) u_sampler (
    .clk        (clk_in),
    .rst        (rst_in),
    .en         (rdy_in),
    .clr        (flush_in),
    .push_valid (push_valid),
    .push_idx   (push_idx),
    .din        (mem_din),
    .mat_valid  (mat_valid),
    .mat_idx    (mat_idx),
    .bytes      (bytes)
  );

  // Byte 0 arriving as a full-width opcode releases bytes 2 and 3 immediately,
  // so the decision uses mem_din rather than the registered copy.
  assign full_go   = (state == ICR_READ) && mat_valid && (mat_idx == 2'd0) && !is_rvc(mem_din);
  assign comp_now  = (mat_idx == 2'd1);
  assign last_byte = (state == ICR_READ) && mat_valid &&
                     ((comp_now && is_rvc(bytes[0])) || (mat_idx == 2'd3));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                  <= ICR_IDLE;
      base                   <= '0;
      issue                  <= 1'b0;
      issue_idx              <= '0;
      busy                   <= 1'b0;
      mem_req                <= 1'b0;
      mem_a                  <= '0;
      write_ic_rdy           <= 1'b0;
      write_ic_addr          <= '0;
      write_ic_data          <= '0;
      write_ic_is_compressed <= 1'b0;
`ifdef ICR_PERF_EN
      perf_refills           <= '0;
      perf_compressed        <= '0;
      perf_flushed           <= '0;
`endif
    end else if (rdy_in) begin
`ifdef ICR_PERF_EN
      // The cache takes the write on any rdy cycle the strobe is up, flush or not.
      if (write_ic_rdy) begin
        perf_refills <= perf_refills + 32'd1;
        if (write_ic_is_compressed) perf_compressed <= perf_compressed + 32'd1;
      end
      if (flush_in && state != ICR_IDLE) perf_flushed <= perf_flushed + 32'd1;
`endif
      if (flush_in) begin
        state        <= ICR_IDLE;
        busy         <= 1'b0;
        mem_req      <= 1'b0;
        write_ic_rdy <= 1'b0;
        issue        <= 1'b0;
      end else begin
        case (state)
          ICR_IDLE: begin
            if (miss_valid) begin
              base    <= miss_addr;
              mem_a   <= {miss_addr, 1'b0};
              state   <= ICR_REQ;
              busy    <= 1'b1;
              mem_req <= 1'b1;
            end
          end
          ICR_REQ: begin
            if (mem_req && mem_gnt) begin
              state     <= ICR_READ;
              issue     <= 1'b1;
              issue_idx <= 2'd1;
              mem_a     <= mem_a + 32'd1;
            end
          end
          ICR_READ: begin
            if (full_go) begin
              issue     <= 1'b1;
              issue_idx <= 2'd2;
              mem_a     <= mem_a + 32'd1;
            end else if (issue) begin
              if (issue_idx == 2'd2) begin
                issue_idx <= 2'd3;
                mem_a     <= mem_a + 32'd1;
              end else begin
                // Byte 1 or byte 3 done; mem_a parks on its last value.
                issue <= 1'b0;
              end
            end
            if (last_byte) begin
              state                  <= ICR_WRITE;
              issue                  <= 1'b0;
              mem_req                <= 1'b0;
              write_ic_rdy           <= 1'b1;
              write_ic_addr          <= base;
              write_ic_is_compressed <= comp_now;
              write_ic_data          <= comp_now ? {16'h0000, mem_din, bytes[0]}
                                                 : {mem_din, bytes[2], bytes[1], bytes[0]};
            end
          end
          ICR_WRITE: begin
            state        <= ICR_IDLE;
            busy         <= 1'b0;
            write_ic_rdy <= 1'b0;
          end
          default: state <= ICR_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - directed self-checking bench for icache_refill at RD_LATENCY 1 and 2
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        miss_valid;
  logic [30:0] miss_addr;
  logic        mem_gnt;

  logic        busy1, req1, wr1, wc1;
  logic [31:0] a1, wd1;
  logic [30:0] wa1;
  logic [7:0]  din1;
  logic        busy2, req2, wr2, wc2;
  logic [31:0] a2, wd2;
  logic [30:0] wa2;
  logic [7:0]  din2;
  logic [7:0]  d2_s;

`ifdef ICR_PERF_EN
  logic [31:0] pr1, pc1, pf1, pr2, pc2, pf2;
`endif

  always #5 clk = ~clk;

  icache_refill #(.RD_LATENCY(1)) dut1 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .busy(busy1),
    .mem_req(req1), .mem_gnt(mem_gnt), .mem_a(a1), .mem_din(din1),
    .write_ic_rdy(wr1), .write_ic_addr(wa1), .write_ic_data(wd1),
    .write_ic_is_compressed(wc1)
`ifdef ICR_PERF_EN
    , .perf_refills(pr1), .perf_compressed(pc1), .perf_flushed(pf1)
`endif
  );

  icache_refill #(.RD_LATENCY(2)) dut2 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .busy(busy2),
    .mem_req(req2), .mem_gnt(mem_gnt), .mem_a(a2), .mem_din(din2),
    .write_ic_rdy(wr2), .write_ic_addr(wa2), .write_ic_data(wd2),
    .write_ic_is_compressed(wc2)
`ifdef ICR_PERF_EN
    , .perf_refills(pr2), .perf_compressed(pc2), .perf_flushed(pf2)
`endif
  );

  // Memory model: four bytes at tbl_base, everything else reads 0xEE.
  logic [31:0] tbl_base = 32'h0;
  logic [7:0]  tbl [4];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] off;
    off = a - tbl_base;
    if (off < 32'd4) return tbl[off[1:0]];
    return 8'hEE;
  endfunction

  always @(posedge clk) begin
    if (rdy) begin
      din1 <= mem_byte(a1);
      d2_s <= mem_byte(a2);
      din2 <= d2_s;
    end
  end

  int cyc = 0;
  int g_cyc = -100;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe capture (only rdy cycles consume a strobe) and mem_a log relative to grant.
  int          stb1_n = 0, stb2_n = 0, stb1_cyc = 0, stb2_cyc = 0;
  logic [31:0] stb1_data = '0, stb2_data = '0;
  logic [30:0] stb1_addr = '0;
  logic        stb1_comp = 1'b0;
  logic [31:0] ma_log1 [16];

  always @(negedge clk) begin
    if (rdy && wr1) begin
      stb1_n    <= stb1_n + 1;
      stb1_cyc  <= cyc;
      stb1_data <= wd1;
      stb1_addr <= wa1;
      stb1_comp <= wc1;
    end
    if (rdy && wr2) begin
      stb2_n    <= stb2_n + 1;
      stb2_cyc  <= cyc;
      stb2_data <= wd2;
    end
    if (cyc - g_cyc >= 0 && cyc - g_cyc < 16) ma_log1[4'(cyc - g_cyc)] <= a1;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy1 && !busy2) break;
      step();
    end
    check("idle_timeout", {30'd0, busy1, busy2}, 32'd0);
    step();
  endtask

  task automatic load_tbl(input logic [30:0] addr, input logic [31:0] b);
    tbl_base = {addr, 1'b0};
    tbl[0] = b[7:0];
    tbl[1] = b[15:8];
    tbl[2] = b[23:16];
    tbl[3] = b[31:24];
  endtask

  // Miss, immediate grant in the first REQ cycle, then run to idle.
  task automatic do_refill(input logic [30:0] addr, input logic [31:0] b, output int g);
    load_tbl(addr, b);
    miss_valid = 1'b1;
    miss_addr  = addr;
    step();
    miss_valid = 1'b0;
    mem_gnt = 1'b1;
    g = cyc;
    g_cyc = cyc;
    step();
    mem_gnt = 1'b0;
    wait_idle();
  endtask

  int g, n1, n2;
  logic req_ok, a_ok;

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; miss_valid = 1'b0;
    miss_addr = '0; mem_gnt = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_req", req1, 0);
    check("rst_wr", wr1, 0);
    check("rst_mem_a", a1, 0);
    check("rst_waddr", wa1, 0);
    check("rst_wdata", wd1, 0);
    check("rst_comp", wc1, 0);
    check("rst_busy2", busy2, 0);

    // Compressed at byte 0x40
    n1 = stb1_n; n2 = stb2_n;
    do_refill(31'h20, 32'hDEAD_4501, g);
    check("c_count", stb1_n - n1, 1);
    check("c_lat", stb1_cyc - g, 3);
    check("c_addr", stb1_addr, 32'h20);
    check("c_data", stb1_data, 32'h0000_4501);
    check("c_comp", stb1_comp, 1);
    check("c_mem_a0", ma_log1[0], 32'h40);
    check("c_mem_a2_hold", ma_log1[2], 32'h41);
    check("c_mem_a3_hold", ma_log1[3], 32'h41);
    check("c_l2_count", stb2_n - n2, 1);
    check("c_l2_lat", stb2_cyc - g, 4);
    check("c_l2_data", stb2_data, 32'h0000_4501);

    // Full 32-bit at byte 0x80
    n1 = stb1_n; n2 = stb2_n;
    do_refill(31'h40, 32'h0010_0513, g);
    check("f_count", stb1_n - n1, 1);
    check("f_lat", stb1_cyc - g, 5);
    check("f_data", stb1_data, 32'h0010_0513);
    check("f_comp", stb1_comp, 0);
    check("f_mem_a0", ma_log1[0], 32'h80);
    check("f_mem_a1", ma_log1[1], 32'h81);
    check("f_mem_a2", ma_log1[2], 32'h82);
    check("f_mem_a3", ma_log1[3], 32'h83);
    check("f_l2_lat", stb2_cyc - g, 7);
    check("f_l2_data", stb2_data, 32'h0010_0513);

    // Address wrap at 0xFFFFFFFE
    do_refill(31'h7FFF_FFFF, 32'h0010_0093, g);
    check("w_mem_a1", ma_log1[1], 32'hFFFF_FFFF);
    check("w_mem_a2", ma_log1[2], 32'h0000_0000);
    check("w_mem_a3", ma_log1[3], 32'h0000_0001);
    check("w_data", stb1_data, 32'h0010_0093);
    check("w_addr", stb1_addr, 31'h7FFF_FFFF);
    check("w_l2_data", stb2_data, 32'h0010_0093);

    // Flush and miss together in IDLE: flush wins
    miss_valid = 1'b1; miss_addr = 31'h50; flush = 1'b1;
    step();
    miss_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", busy1, 0);
    step();

    // Flush in the cycle after grant, then a new miss
    n1 = stb1_n; n2 = stb2_n;
    load_tbl(31'h80, 32'h0000_0413);
    miss_valid = 1'b1; miss_addr = 31'h80;
    step();
    miss_valid = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("fl_req", req1, 0);
    check("fl_busy", busy1, 0);
    check("fl_req2", req2, 0);
    check("fl_no_stb", stb1_n - n1, 0);
    do_refill(31'h90, 32'h0000_9102, g);
    check("fl_re_count", stb1_n - n1, 1);
    check("fl_re_data", stb1_data, 32'h0000_9102);
    check("fl_re_comp", stb1_comp, 1);
    check("fl_re_lat", stb1_cyc - g, 3);
    check("fl_re_l2_count", stb2_n - n2, 1);

    // Withheld grant, rdy stalls in READ and in WRITE
    n1 = stb1_n; n2 = stb2_n;
    load_tbl(31'h100, 32'h1050_0073);
    miss_valid = 1'b1; miss_addr = 31'h100;
    step();
    miss_valid = 1'b0;
    req_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      req_ok &= req1;
      step();
    end
    mem_gnt = 1'b1; g = cyc; g_cyc = cyc;
    step();
    mem_gnt = 1'b0; rdy = 1'b0;
    a_ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      req_ok &= req1;
      a_ok &= (a1 == 32'h201);
      step();
    end
    rdy = 1'b1;
    repeat (4) step();
    rdy = 1'b0;
    @(negedge clk);
    check("st_wr_held", wr1, 1);
    check("st_no_stb_yet", stb1_n - n1, 0);
    repeat (3) step();
    rdy = 1'b1;
    wait_idle();
    check("st_req_held", req_ok, 1);
    check("st_mem_a_frozen", a_ok, 1);
    check("st_count", stb1_n - n1, 1);
    check("st_lat", stb1_cyc - g, 11);
    check("st_data", stb1_data, 32'h1050_0073);
    check("st_l2_count", stb2_n - n2, 1);
    check("st_l2_data", stb2_data, 32'h1050_0073);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Miss-refill engine that sits directly upstream of the instruction cache. It takes a fetch-miss halfword address and reads instruction bytes over the shared byte-wide memory bus. It detects RVC compression from byte 0, then writes one cache entry through the cache's write port (write_ic_*).
- The fetch stage raises a miss when the cache's read_ic_rdy is low.
- A memory arbiter grants the bus.

Parameters:
- RD_LATENCY, 1: cycles from presenting mem_a to mem_din being valid. Supported values are 1 and 2.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global enable; when low, all state holds
- flush_in  input  1  abort the current refill (branch mispredict)
- miss_valid  input  1  refill request; sampled in IDLE only
- miss_addr  input  31  halfword address [31:1]; byte address is {miss_addr,1'b0}
- busy  output  1  high in any state other than IDLE
- mem_req  output  1  bus request to arbiter
- mem_gnt  input  1  arbiter grant; bus stays owned until mem_req drops
- mem_a  output  32  byte address to memory
- mem_din  input  8  read data from memory
- write_ic_rdy  output  1  cache write strobe
- write_ic_addr  output  31  [31:1] address of the filled entry
- write_ic_data  output  32  instruction; upper 16 bits are zero when compressed
- write_ic_is_compressed  output  1  byte0[1:0] != 2'b11

Behaviour:
- Reset: state=IDLE. busy, mem_req, write_ic_rdy, write_ic_is_compressed = 0; mem_a, write_ic_addr, write_ic_data = 0; byte buffer cleared. Reset mid-refill abandons it with no write.
- rdy_in=0: every register holds, including a pending write_ic_rdy. The cache also ignores writes while rdy_in=0, so the pulse is consumed on the next rdy cycle.
- States:
  - IDLE: on miss_valid and not flush_in, latch base=miss_addr, go to REQ. There is no request buffering; miss_valid is ignored while busy.
  - REQ: mem_req=1; on mem_gnt go to READ. The grant cycle also presents mem_a=base byte 0.
  - READ: mem_a steps by one byte each cycle.
    - Byte k is presented in cycle t and sampled from mem_din at the end of cycle t+RD_LATENCY.
    - Bytes 0 and 1 are always issued back-to-back.
    - Bytes 2 and 3 are issued only after byte 0 has been sampled and byte0[1:0]==2'b11. mem_a holds its last value while the block waits.
    - Go to WRITE after the last needed byte is sampled: byte 1 if compressed, byte 3 otherwise.
  - WRITE: drop mem_req; write_ic_rdy=1 for exactly one rdy cycle. Drive write_ic_addr=base, write_ic_data={b3,b2,b1,b0} or {16'b0,b1,b0}, and is_compressed. Next state is IDLE.
- Latency (RD_LATENCY=1, gnt in cycle G):
  - Compressed: write strobe in cycle G+3.
  - Full 32-bit: mem_a = A, A+1 in G, G+1; A+2, A+3 in G+2, G+3; write strobe in G+5.
- Address arithmetic is mod 2^32: base 0xFFFFFFFE with a non-compressed instruction reads bytes 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- flush_in:
  - Checked before anything else each rdy cycle.
  - In REQ, READ or WRITE, it forces IDLE on the next edge: mem_req=0, write_ic_rdy=0, in-flight bytes discarded.
  - In IDLE, flush and miss in the same cycle means flush wins and the miss is dropped.
- mem_gnt is only observed while mem_req=1.
- write_ic_rdy is never high outside WRITE.

Optional Feature:
- ICR_PERF_EN defined:
  - Adds 32-bit output counters perf_refills, perf_compressed and perf_flushed, all wrapping.
  - perf_refills and perf_compressed count write strobes (perf_compressed only those with is_compressed=1).
  - perf_flushed counts flushes taken in a non-IDLE state.
  - All counters reset to 0 and hold when rdy_in=0.
- Not defined: those ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- params.v: state encodings (ICR_IDLE, ICR_REQ, ICR_READ, ICR_WRITE) and the RVC opcode mask 2'b11. IC_WIDTH stays there; it is unused here.
- One natural sub-module, icr_byte_sampler: a RD_LATENCY-deep shift of a (valid, index) tag alongside mem_a. It steers mem_din into b0..b3 when a tag matures, and is cleared by flush or reset.

Test Plan:
- miss_addr=0x40>>1, memory bytes 0x01,0x45 -> one strobe at G+3; write_ic_addr=0x20, data=0x00004501, is_compressed=1; bytes 2 and 3 never addressed.
- miss at 0x80, bytes 0x13,0x05,0x10,0x00 -> strobe at G+5; data=0x00100513, is_compressed=0; mem_a sequence 0x80..0x83.
- Base 0xFFFFFFFE, bytes 0x93,0x00,0x10,0x00 -> mem_a wraps to 0x00000000 and 0x00000001; data=0x00100093.
- flush_in in the cycle after grant -> mem_req low on the next edge; no strobe; a new miss in the following cycle refills correctly.
- mem_gnt withheld for 5 cycles, then rdy_in=0 for 3 cycles during READ and again during WRITE -> mem_req held throughout; mem_a frozen; exactly one strobe delivered on a rdy cycle.
- RD_LATENCY=2 with the compressed and full cases above -> same data; strobes at G+4 and G+7.
